gelato_fetchskd_ifetch_queue: RTL
=================================

# gelato_fetchskd_ifetch_queue

Parametrised request queue between the fetch scheduler and the I-fetch stage, replacing the single-slot `caught`/`valid` exchange with a DEPTH-entry FIFO and independent valid/ready handshakes on both sides. Each entry carries a fetch request: PC, warp number and split-table number. The queue supports per-warp flush, so a redirected warp's stale requests are killed without draining the whole queue.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `COUNT_WIDTH`, $clog2(DEPTH)+1, width of the occupancy output.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the scheduler offers a request.
- `in_ready` output 1: the queue accepts the request this cycle.
- `in_pc` input addr_t: PC of the offered request.
- `in_warp_num` input warp_num_t: warp of the offered request.
- `in_split_table_num` input split_table_num_t: split-table entry of the offered request.
- `out_valid` output 1: head request presented to I-fetch.
- `out_ready` input 1: I-fetch takes the head.
- `out_pc`, `out_warp_num`, `out_split_table_num` output (types as above): head request fields.
- `flush_valid` input 1: kill all requests of one warp.
- `flush_warp_num` input warp_num_t: warp to kill.
- `count` output COUNT_WIDTH: occupied slots, including killed slots not yet retired.

## Operation
- Storage: DEPTH × fetch_req_t plus a per-slot `live` bit. Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `full = (count == DEPTH)`, `empty = (count == 0)`.
- Push: `in_valid && in_ready` writes the tail slot with `live = 1` and advances the tail. `in_ready = !full`, derived from registered `count` only. There is no combinational path from `out_ready`, so a full queue refuses a push even while it pops.
- Pop: `out_valid = !empty && live[head]`. `out_valid && out_ready` retires the head.
- Hole retire: if the queue is not empty and `live[head] == 0`, the head slot retires automatically that cycle with `out_valid = 0`. One slot retires per cycle at most.
- Flush: `flush_valid` clears `live` on every slot whose warp equals `flush_warp_num`. A push of the same warp in the same cycle is written with `live = 0`. The head is not presented in the flush cycle if it matches: `out_valid` is qualified by the same-cycle flush match.
- Count: next `count` = `count` + push − (pop or hole retire).
- Reset: all `live` bits cleared, pointers 0, `count` 0, so `out_valid` = 0 and `in_ready` = 1. Reset mid-operation discards all contents immediately.
- `out_*` fields are don't-care when `out_valid` = 0; they are driven from the head slot.

## Timing
- Enqueue-to-dequeue latency: 1 cycle. A request pushed in cycle N is presented at the earliest in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained when neither full nor empty.
- Flush takes effect in the same cycle. A killed head costs one bubble cycle to retire.
- Simultaneous push and pop with `count` = k (0 < k < DEPTH): `count` stays k.

## Configuration
- `GELATO_FETCHQ_BYPASS_EN` defined: when `empty`, `in_valid`, `out_ready` and no same-warp flush all hold, the input request is forwarded combinationally to `out_*` with `out_valid = 1`. It is not written, and `count` is unchanged (0-cycle latency).
- Not defined: no bypass. Every request spends at least one cycle in storage.

## Structure
- In `gelato_types`: `fetch_req_t` struct {addr_t pc; warp_num_t warp_num; split_table_num_t split_table_num} and `GELATO_FETCHQ_DEPTH` (default 4).
- One sub-module, `gelato_fetchq_ptr`: a wrapping pointer with increment enable and async reset, instantiated for head and tail.
- Storage, live bits and count logic stay in the top module.

## Test plan
- Reset, then push PCs 0x100/0x104/0x108/0x10C (warps 0–3) with `out_ready` = 0 → `count` = 4, `in_ready` = 0. Raise `out_ready` → the four PCs pop in order, one per cycle, and `count` returns to 0.
- Full queue, with `in_valid` and `out_ready` both high → exactly one pop, no push; the next cycle `in_ready` = 1 and `count` = 3.
- Queue holds warps 2,5,2,7; flush warp 2 → output sequence is bubble, warp 5, bubble, warp 7, and `count` reaches 0 after 4 cycles.
- Push warp 3 in the same cycle as a flush of warp 3 → the request is never presented and retires as a hole.
- Assert `rst` with 3 entries queued → next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1, and no stale PC appears afterwards.
- With `GELATO_FETCHQ_BYPASS_EN`: empty queue, push PC 0x200 with `out_ready` = 1 → `out_valid` = 1 and `out_pc` = 0x200 in the same cycle, `count` stays 0. Without the macro → 0x200 appears one cycle later.

Source files
------------

// File: rtl/gelato_types.sv
// Shared fetch-path types: request fields, the queued fetch request and the default queue depth.
package gelato_types;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WARP_W  = 3;
  localparam int unsigned SPLIT_W = 4;

  localparam int unsigned GELATO_FETCHQ_DEPTH = 4;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [WARP_W-1:0]  warp_num_t;
  typedef logic [SPLIT_W-1:0] split_table_num_t;

  typedef struct packed {
    addr_t            pc;
    warp_num_t        warp_num;
    split_table_num_t split_table_num;
  } fetch_req_t;

  function automatic logic req_warp_match(fetch_req_t req, warp_num_t warp);
    return req.warp_num == warp;
  endfunction

endpackage

// File: rtl/gelato_fetchq_ptr.sv
// Wrapping queue pointer with increment enable; wraps naturally at 2**WIDTH.
module gelato_fetchq_ptr #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/gelato_fetchskd_ifetch_queue.sv
// DEPTH-entry fetch request queue with per-warp flush between fetch scheduler and I-fetch.
// Optional combinational empty-queue bypass enabled by defining GELATO_FETCHQ_BYPASS_EN.
module gelato_fetchskd_ifetch_queue
  import gelato_types::*;
#(
  parameter int unsigned DEPTH       = GELATO_FETCHQ_DEPTH,
  parameter int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  addr_t                  in_pc,
  input  warp_num_t              in_warp_num,
  input  split_table_num_t       in_split_table_num,
  output logic                   out_valid,
  input  logic                   out_ready,
  output addr_t                  out_pc,
  output warp_num_t              out_warp_num,
  output split_table_num_t       out_split_table_num,
  input  logic                   flush_valid,
  input  warp_num_t              flush_warp_num,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_req_t             mem_q [DEPTH];
  logic [DEPTH-1:0]       live_q, live_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [PtrW-1:0]        head, tail;

  fetch_req_t in_req, head_req;
  logic       full, empty;
  logic       head_kill, head_live, in_kill;
  logic       bypass, push, pop, retire;

  assign in_req = '{pc: in_pc, warp_num: in_warp_num, split_table_num: in_split_table_num};

  always_comb begin
    full      = (count_q == COUNT_WIDTH'(DEPTH));
    empty     = (count_q == '0);
    head_req  = mem_q[head];
    // A head killed by this cycle's flush is already a hole: hidden and retired now.
    head_kill = flush_valid && req_warp_match(head_req, flush_warp_num);
    head_live = live_q[head] && !head_kill;
    in_kill   = flush_valid && (in_warp_num == flush_warp_num);
`ifdef GELATO_FETCHQ_BYPASS_EN
    bypass    = empty && in_valid && out_ready && !in_kill;
`else
    bypass    = 1'b0;
`endif
    in_ready  = !full;
    push      = in_valid && !full && !bypass;
    pop       = !empty && head_live && out_ready;
    retire    = pop || (!empty && !head_live);

    out_valid = (!empty && head_live) || bypass;
    if (bypass) begin
      out_pc              = in_req.pc;
      out_warp_num        = in_req.warp_num;
      out_split_table_num = in_req.split_table_num;
    end else begin
      out_pc              = head_req.pc;
      out_warp_num        = head_req.warp_num;
      out_split_table_num = head_req.split_table_num;
    end
  end

  always_comb begin
    live_d = live_q;
    if (flush_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (req_warp_match(mem_q[i], flush_warp_num)) begin
          live_d[i] = 1'b0;
        end
      end
    end
    if (retire) begin
      live_d[head] = 1'b0;
    end
    // Tail is never the occupied head when pushing, so this cannot collide with retire.
    if (push) begin
      live_d[tail] = !in_kill;
    end
    count_d = count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(retire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q  <= '0;
      count_q <= '0;
    end else begin
      live_q  <= live_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail] <= in_req;
    end
  end

  gelato_fetchq_ptr #(
    .WIDTH(PtrW)
  ) u_head_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(retire),
    .ptr_o(head)
  );

  gelato_fetchq_ptr #(
    .WIDTH(PtrW)
  ) u_tail_ptr (
    .clk  (clk),
    .rst  (rst),
    .inc_i(push),
    .ptr_o(tail)
  );

  assign count = count_q;

endmodule
